// File: rtl/fp_sqrt_core.sv
// Sequential radix-2 restoring square root: out = floor(sqrt(in * 2^WIDTH)), sticky = inexact.
// Optional build macro SQRT_ZERO_BYPASS_EN: a zero radicand skips the iteration loop.
module fp_sqrt_core #(
    parameter int  WIDTH = 26,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH+1:0] rem;
        logic [WIDTH-1:0] root;
    } step_t;

    // One restoring iteration: bring down two radicand bits, try subtracting {root,01}.
    // rem stays below 2*root+2, so dropping the bits shifted out the top loses nothing.
    function automatic step_t sqrt_step(input logic [WIDTH+1:0] rem,
                                        input logic [1:0]       bits,
                                        input logic [WIDTH-1:0] root);
        logic [WIDTH+1:0] rem_t;
        logic [WIDTH+1:0] trial;
        step_t            res;
        rem_t = (rem << 2) | {{WIDTH{1'b0}}, bits};
        trial = {root, 2'b01};
        if (rem_t >= trial) begin
            res.rem  = rem_t - trial;
            res.root = (root << 1) | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res.rem  = rem_t;
            res.root = root << 1;
        end
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] rad_q, rad_d;
    logic [WIDTH+1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   root_q, root_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               sticky_q, sticky_d;
    step_t              step;

    always_comb begin
        state_d  = state_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        sticky_d = sticky_q;
        step     = sqrt_step(rem_q, rad_q[2*WIDTH-1:2*WIDTH-2], root_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    rad_d   = {in, {WIDTH{1'b0}}};
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = CALC;
`ifdef SQRT_ZERO_BYPASS_EN
                    if (in == '0) begin
                        out_d    = '0;
                        sticky_d = 1'b0;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rad_d  = rad_q << 2;
                rem_d  = step.rem;
                root_d = step.root;
                // Result is latched on entry to DONE so it is valid while done is high.
                if (cnt_q == '0) begin
                    out_d    = step.root;
                    sticky_d = |step.rem;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            sticky_q <= sticky_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign out    = out_q;
    assign sticky = sticky_q;

endmodule
